// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions for the host-side keyboard transmitter.
// Contents:
//   state_t      - transmitter FSM states
//   CMD_* / RSP_* - common keyboard command and response bytes
//   make_frame() - builds the 10-bit {stop, parity, data} shift frame
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  // Host-to-keyboard commands.
  localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
  localparam logic [7:0] CMD_ENABLE    = 8'hF4;

  // Keyboard-to-host responses.
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

  // Bits shifted out after the start bit: 8 data bits LSB first, odd parity,
  // then the stop bit (1 = line released).
  function automatic logic [9:0] make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock falling-edge detector with glitch rejection.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   ps2_clk    - raw (asynchronous) PS/2 clock line
//   fall       - high for one cycle when the line has been high and then
//                low for three consecutive samples
module ps2_clk_filter (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  output logic fall
);

  // history[3] is the newest sample, history[0] the oldest.
  logic [3:0] history;

  // NOTE: clocked state uses non-blocking assignments so every register in
  // the design samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      history <= 4'b1111;
    end else begin
      history <= {ps2_clk, history[3:1]};
    end
  end

  // A low pulse shorter than three samples never produces this pattern.
  assign fall = (history == 4'b0001);

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter for the keyboard port.
// Pulls the clock line low to inhibit, presents the start bit, then shifts
// data/parity/stop on device-generated clock falls and checks the ACK bit.
// Ports:
//   clk, reset                      - system clock, synchronous active-high reset
//   ps2_kbd_clk, ps2_kbd_data       - raw PS/2 line samples (asynchronous)
//   ps2_kbd_clk_oe, ps2_kbd_data_oe - 1 = pull the line low (open drain)
//   tx_data, tx_valid, tx_ready     - byte request handshake
//   busy                            - transfer in flight (gate the receiver)
//   tx_done, tx_error               - one-cycle completion / failure pulses
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2200,
  parameter int TIMEOUT_CYCLES = 43000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       ps2_kbd_clk_oe,
  output logic       ps2_kbd_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_inc;
  logic [9:0]       frame;
  logic [3:0]       bit_idx;
  logic             fall;
  logic             wd_expired;

  ps2_clk_filter u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_kbd_clk),
    .fall    (fall)
  );

  // Saturating increment: the counter never wraps back to zero.
  assign counter_inc = (counter == '1) ? counter : counter + 1'b1;

  // Watchdog covers everything from clock release to the bus going idle.
  assign wd_expired = (state inside {ST_REQ, ST_SEND, ST_ACK, ST_WAIT_IDLE}) &&
                      (counter == TIMEOUT_LAST);

  assign busy = ~tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      ps2_kbd_clk_oe  <= 1'b0;
      ps2_kbd_data_oe <= 1'b0;
      tx_ready        <= 1'b1;
      tx_done         <= 1'b0;
      tx_error        <= 1'b0;
      counter         <= '0;
      bit_idx         <= '0;
      frame           <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      // Expiry wins over a fall seen in the same cycle.
      if (wd_expired) begin
        ps2_kbd_clk_oe  <= 1'b0;
        ps2_kbd_data_oe <= 1'b0;
        tx_error        <= 1'b1;
        tx_ready        <= 1'b1;
        state           <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            ps2_kbd_clk_oe  <= 1'b0;
            ps2_kbd_data_oe <= 1'b0;
            if (tx_valid && tx_ready) begin
              frame          <= make_frame(tx_data);
              counter        <= '0;
              ps2_kbd_clk_oe <= 1'b1;  // inhibit starts on the accept edge
              tx_ready       <= 1'b0;
              state          <= ST_INHIBIT;
            end
          end

          ST_INHIBIT: begin
            if (counter == INHIBIT_LAST) begin
              ps2_kbd_data_oe <= 1'b1;  // start bit
              counter         <= '0;
              bit_idx         <= '0;
              state           <= ST_REQ;
            end else begin
              counter <= counter_inc;
            end
          end

          ST_REQ: begin
            counter        <= counter_inc;
            ps2_kbd_clk_oe <= 1'b0;     // hand the clock to the device
            state          <= ST_SEND;
          end

          ST_SEND: begin
            counter <= counter_inc;
            if (fall) begin
              ps2_kbd_data_oe <= ~frame[bit_idx];
              bit_idx         <= bit_idx + 4'd1;
              if (bit_idx == 4'd9) begin
                state <= ST_ACK;
              end
            end
          end

          ST_ACK: begin
            counter <= counter_inc;
            if (fall) begin
              // The device pulls data low while clocking the ACK bit.
              if (!ps2_kbd_data) begin
                state <= ST_WAIT_IDLE;
              end else begin
                tx_error <= 1'b1;
                tx_ready <= 1'b1;
                state    <= ST_IDLE;
              end
            end
          end

          ST_WAIT_IDLE: begin
            counter <= counter_inc;
            // Raw lines: the device has already stopped clocking here, so a
            // one-cycle-late decision on a metastable sample is harmless.
            if (ps2_kbd_clk && ps2_kbd_data) begin
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              state    <= ST_IDLE;
            end
          end

          default: begin
            ps2_kbd_clk_oe  <= 1'b0;
            ps2_kbd_data_oe <= 1'b0;
            tx_ready        <= 1'b1;
            state           <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple keyboard-side clock/ACK model.
// Timing is scaled down (short inhibit, short watchdog, fast device clock).
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH  = 50;
  localparam int TMO  = 3000;
  localparam int HALF = 40;

  // Hand-computed {stop, parity, data} frames.
  localparam logic [9:0] EXP_ED = 10'h3ED;
  localparam logic [9:0] EXP_FF = 10'h3FF;
  localparam logic [9:0] EXP_F4 = 10'h2F4;
  localparam logic [9:0] EXP_F3 = 10'h3F3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bfm_clk = 1'b1;
  logic       bfm_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       line_clk, line_data;
  logic       clk_oe, data_oe, tx_ready, busy, tx_done, tx_error;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  logic [2:0] err_snap = 3'b000;

  // Open-drain wired-AND of host and device.
  assign line_clk  = bfm_clk  & ~clk_oe;
  assign line_data = bfm_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ps2_kbd_clk     (line_clk),
    .ps2_kbd_data    (line_data),
    .ps2_kbd_clk_oe  (clk_oe),
    .ps2_kbd_data_oe (data_oe),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .tx_done         (tx_done),
    .tx_error        (tx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done)  done_cnt <= done_cnt + 1;
    if (tx_error) begin
      err_cnt  <= err_cnt + 1;
      err_snap <= {clk_oe, data_oe, tx_ready};
    end
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Wait until the host has released the clock with the start bit driven.
  task automatic wait_send(input string tag);
    int i = 0;
    while (!(!clk_oe && data_oe) && i < INH + 20) begin
      tick();
      i++;
    end
    check(tag, {31'd0, (!clk_oe && data_oe)}, 32'd1);
  endtask

  // Device model: nfalls clock periods; records the data line late in each
  // low phase of falls 1..10. On fall 11 it pulls data low if ack is set and
  // leaves it low for the caller to release.
  task automatic bfm_frame(input bit ack, input bit glitch, input int nfalls,
                           output logic [9:0] seen);
    seen = '0;
    tick(10);
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11 && ack) bfm_data = 1'b0;
      bfm_clk = 1'b0;
      tick(HALF);
      if (i <= 10) seen[i-1] = line_data;
      bfm_clk = 1'b1;
      if (glitch && i <= 10) begin
        tick(10);
        bfm_clk = 1'b0;
        tick(2);
        bfm_clk = 1'b1;
        tick(HALF - 12);
      end else begin
        tick(HALF);
      end
    end
  endtask

  initial begin
    logic [9:0] seen;
    int d0, e0, k, rise_at, clk_high;

    // Reset state
    tick(3);
    check("rst_clk_oe",   clk_oe,   0);
    check("rst_data_oe",  data_oe,  0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy",     busy,     0);
    check("rst_tx_done",  tx_done,  0);
    check("rst_tx_error", tx_error, 0);
    reset = 1'b0;
    tick(5);

    // 1: 0xED with ACK, per-bit line values
    d0 = done_cnt; e0 = err_cnt;
    accept(CMD_SET_LEDS);
    check("t1_busy", busy, 1);
    wait_send("t1_reach_send");
    bfm_frame(1'b1, 1'b0, 11, seen);
    for (int b = 0; b < 10; b++) check($sformatf("t1_bit%0d", b), seen[b], EXP_ED[b]);
    check("t1_no_done_before_idle", done_cnt - d0, 0);
    bfm_data = 1'b1;
    tick(20);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_no_error",  err_cnt - e0,  0);
    check("t1_ready",     tx_ready,      1);

    // 2: 0xFF inhibit timing
    d0 = done_cnt; e0 = err_cnt;
    tx_data = CMD_RESET; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("t2_clk_oe_latency", clk_oe, 1);
    clk_high = 0; rise_at = -1;
    for (int j = 0; j < INH + 10; j++) begin
      if (clk_oe) clk_high++;
      if (data_oe && rise_at < 0) rise_at = j;
      tick();
    end
    check("t2_clk_oe_cycles",  clk_high, INH + 1);
    check("t2_data_oe_rise",   rise_at,  INH);
    bfm_frame(1'b1, 1'b0, 11, seen);
    check("t2_frame", seen, EXP_FF);
    bfm_data = 1'b1;
    tick(20);
    check("t2_done", done_cnt - d0, 1);
    check("t2_no_error", err_cnt - e0, 0);

    // 3: no ACK
    d0 = done_cnt; e0 = err_cnt;
    accept(CMD_ENABLE);
    wait_send("t3_reach_send");
    bfm_frame(1'b0, 1'b0, 11, seen);
    tick(5);
    check("t3_frame",       seen,          EXP_F4);
    check("t3_error_once",  err_cnt - e0,  1);
    check("t3_no_done",     done_cnt - d0, 0);
    check("t3_oe_ready_at_error", err_snap, 3'b001);

    // 4: device never clocks -> watchdog
    d0 = done_cnt; e0 = err_cnt;
    accept(CMD_TYPEMATIC);
    k = 0;
    while (!data_oe && k < INH + 10) begin
      tick();
      k++;
    end
    check("t4_req_entry", data_oe, 1);
    k = 0;
    while (!tx_error && k < TMO + 50) begin
      tick();
      k++;
    end
    check("t4_timeout_cycles", k, TMO);
    check("t4_clk_oe",   clk_oe,   0);
    check("t4_data_oe",  data_oe,  0);
    check("t4_ready",    tx_ready, 1);
    tick(5);
    check("t4_error_once", err_cnt - e0,  1);
    check("t4_no_done",    done_cnt - d0, 0);

    // 5: reset during SEND, then a fresh 0xF4
    accept(CMD_SET_LEDS);
    wait_send("t5_reach_send");
    bfm_frame(1'b1, 1'b0, 4, seen);
    d0 = done_cnt; e0 = err_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_clk_oe",  clk_oe,   0);
    check("t5_rst_data_oe", data_oe,  0);
    check("t5_rst_ready",   tx_ready, 1);
    tick(20);
    check("t5_rst_no_done",  done_cnt - d0, 0);
    check("t5_rst_no_error", err_cnt - e0,  0);
    accept(CMD_ENABLE);
    wait_send("t5_reach_send2");
    bfm_frame(1'b1, 1'b0, 11, seen);
    check("t5_frame", seen, EXP_F4);
    bfm_data = 1'b1;
    tick(20);
    check("t5_done",     done_cnt - d0, 1);
    check("t5_no_error", err_cnt - e0,  0);

    // 6: clock glitches and a request while busy
    d0 = done_cnt; e0 = err_cnt;
    accept(CMD_TYPEMATIC);
    tx_data  = CMD_RESET;
    tx_valid = 1'b1;
    wait_send("t6_reach_send");
    tx_valid = 1'b0;
    bfm_frame(1'b1, 1'b1, 11, seen);
    check("t6_frame", seen, EXP_F3);
    bfm_data = 1'b1;
    tick(20);
    check("t6_done",     done_cnt - d0, 1);
    check("t6_no_error", err_cnt - e0,  0);
    clk_high = 0;
    for (int j = 0; j < 100; j++) begin
      if (clk_oe) clk_high++;
      tick();
    end
    check("t6_no_second_frame", clk_high, 0);
    check("t6_ready", tx_ready, 1);
    check("never_done_and_error", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter for the keyboard port; sends command and data bytes to the keyboard, e.g. 0xED LED-set, 0xFF reset, 0xF3 typematic.
- Drives the PS/2 clock and data lines open-drain through active-high pull-low enables; top level maps enable=1 to a driven 0, else Z.
- Sits beside the existing keyboard receiver on the same two lines; `busy` lets the top level gate the receiver while a host transfer is in flight.

Parameters:
- INHIBIT_CYCLES, 2200, clk cycles the clock line is held low before the start bit (≥100 µs at 21.477 MHz).
- TIMEOUT_CYCLES, 43000, watchdog limit from clock release to ACK-complete (≈2 ms).
- CNT_W, 16, width of the shared cycle counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ps2_kbd_clk  in  1  sampled PS/2 clock line, asynchronous.
- ps2_kbd_data  in  1  sampled PS/2 data line, asynchronous.
- ps2_kbd_clk_oe  out  1  1 = pull clock line low.
- ps2_kbd_data_oe  out  1  1 = pull data line low.
- tx_data  in  8  byte to send; captured on accept.
- tx_valid  in  1  request; accepted when tx_valid & tx_ready.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  ~tx_ready.
- tx_done  out  1  one-cycle pulse; device ACKed and the bus returned idle.
- tx_error  out  1  one-cycle pulse; no ACK or watchdog expiry.

Behaviour:
- Reset: one clock, synchronous, active-high. Next cycle: state IDLE, both oe=0, tx_ready=1, busy=0, tx_done=0, tx_error=0, counter=0, clk filter history=4'b1111. Reset mid-transfer releases both lines on the next edge; no done or error pulse is generated.
- Clock filter: 4-bit history shifting in ps2_kbd_clk at the MSB each cycle. `fall` = history==4'b0001, i.e. oldest sample high, three newest low. Glitches shorter than 3 cycles are rejected. The history runs in every state.
- Frame on accept: shift register {stop=1, parity=~^tx_data, tx_data}, 10 bits, LSB first.
- IDLE: both oe=0. On accept: capture the frame, counter=0, go to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0. When counter reaches INHIBIT_CYCLES-1: data_oe=1 (start bit), counter=0, bit_idx=0, go to REQ.
- REQ: one cycle; clk_oe=1 and data_oe=1. Next cycle clk_oe=0, go to SEND.
- SEND: on each `fall`, data_oe = ~frame[bit_idx], then bit_idx++.
  - Falls 1–8 present data bits 0–7, fall 9 presents parity, fall 10 presents stop (data_oe=0).
  - After the 10th fall, go to ACK.
- ACK: on the next `fall`, sample ps2_kbd_data. 0 → go to WAIT_IDLE. 1 → tx_error pulse, go to IDLE.
- WAIT_IDLE: when ps2_kbd_clk=1 and ps2_kbd_data=1 (raw) → tx_done pulse, go to IDLE.
- Watchdog: counter runs in REQ, SEND, ACK and WAIT_IDLE. At TIMEOUT_CYCLES-1: both oe=0, tx_error pulse, go to IDLE. This takes priority over a same-cycle `fall`.
- tx_valid while busy is ignored and not queued; tx_data is don't-care outside accept.
- tx_done and tx_error are never high in the same cycle.
- Latency: accept to first clk_oe=1 is one cycle. Counter saturates and does not wrap.

Decomposition:
- Shared PS/2 package: state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE), command constants 8'hED, 8'hFF, 8'hF3, 8'hF4, and response constants 8'hFA (ACK) and 8'hFE (RESEND).
- One natural sub-module, ps2_clk_filter: 4-sample history with a `fall` output. The existing receiver's edge logic migrates to it later.

Test Plan:
- Send 0xED, device BFM clocks at 12.5 kHz and ACKs → data_oe sequence at falls 1–10 gives line values 1,0,1,1,0,1,1,1, parity 1, stop 1. tx_done pulses once after the lines go high; tx_error stays 0.
- Measure INHIBIT for 0xFF → clk_oe high exactly INHIBIT_CYCLES+1 cycles (INHIBIT plus REQ). data_oe rises INHIBIT_CYCLES cycles after accept.
- BFM leaves data high at the 11th fall → tx_error pulses, both oe=0, tx_ready=1 next cycle, and no tx_done.
- BFM never clocks → tx_error pulse exactly TIMEOUT_CYCLES cycles after entering REQ; lines released.
- Assert reset during SEND bit 4 → both oe=0 next cycle, tx_ready=1, and no pulses. Then a fresh 0xF4 completes with tx_done.
- Inject 2-cycle low glitches on ps2_kbd_clk during SEND → no bit advance. A second tx_valid while busy → ignored; exactly one frame is sent.
